// File: rtl/mod_mult_arbiter.sv
// Round-robin arbiter sharing one modular multiplier among NREQ requesters.
// Optional watchdog on the multiplier wait, enabled by MM_ARB_TIMEOUT_EN.
module mod_mult_arbiter #(
   parameter int N       = 192,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*N-1:0] op_a_i,
   input  logic [NREQ*N-1:0] op_b_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [NREQ-1:0]   done_o,
   output logic [N-1:0]      result_o,
   output logic              busy_o,
   output logic              err_o,
   output logic [N-1:0]      mul_a_o,
   output logic [N-1:0]      mul_b_o,
   output logic              mul_rst_o,
   input  logic [N-1:0]      mul_m_i,
   input  logic              mul_flag_i
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_DONE
   } state_e;

   state_e            state_q;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     idx_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   done_q;
   logic              err_q;
   logic              busy_q;
   logic [N-1:0]      result_q;
   logic [N-1:0]      mul_a_q;
   logic [N-1:0]      mul_b_q;
   logic              mul_rst_q;
`ifdef MM_ARB_TIMEOUT_EN
   logic [31:0]       cnt_q;
`endif

   logic [2*NREQ-1:0] dbl_d;
   logic [NREQ-1:0]   rot_d;
   int                off_d;
   int                sum_d;
   logic [PW-1:0]     sel_d;
   logic [N-1:0]      a_sel_d;
   logic [N-1:0]      b_sel_d;

   // Rotate requests so bit 0 is the requester at ptr, then take lowest set.
   always_comb begin
      dbl_d = {req_i, req_i} >> ptr_q;
      rot_d = dbl_d[NREQ-1:0];
      off_d = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot_d[k]) off_d = k;
      end
      sum_d = 32'(ptr_q) + off_d;
      if (sum_d >= NREQ) sum_d = sum_d - NREQ;
      sel_d = PW'(sum_d);
   end

   always_comb begin
      a_sel_d = '0;
      b_sel_d = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (sel_d == PW'(k)) begin
            a_sel_d = op_a_i[k*N +: N];
            b_sel_d = op_b_i[k*N +: N];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         result_q  <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_rst_q <= 1'b1;
`ifdef MM_ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (|req_i) begin
                  idx_q   <= sel_d;
                  gnt_q   <= NREQ'(1) << sel_d;
                  mul_a_q <= a_sel_d;
                  mul_b_q <= b_sel_d;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               mul_rst_q <= 1'b0;
               state_q   <= S_WAIT;
`ifdef MM_ARB_TIMEOUT_EN
               cnt_q     <= '0;
`endif
            end
            S_WAIT: begin
               if (mul_flag_i) begin
                  result_q  <= mul_m_i;
                  done_q    <= gnt_q;
                  mul_rst_q <= 1'b1;
                  state_q   <= S_DONE;
               end
`ifdef MM_ARB_TIMEOUT_EN
               else if (cnt_q == 32'(TIMEOUT - 1)) begin
                  result_q  <= '0;
                  err_q     <= 1'b1;
                  done_q    <= gnt_q;
                  mul_rst_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
`endif
            end
            S_DONE: begin
               gnt_q   <= '0;
               done_q  <= '0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               ptr_q   <= (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt_o     = gnt_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign busy_o    = busy_q;
   assign result_o  = result_q;
   assign mul_a_o   = mul_a_q;
   assign mul_b_o   = mul_b_q;
   assign mul_rst_o = mul_rst_q;

endmodule

// File: tb/tb_mod_mult_arbiter.sv
// Scoreboard bench for mod_mult_arbiter with a behavioural P-192 multiplier.
// Timeout branch is exercised when MM_ARB_TIMEOUT_EN is defined.
module tb_mod_mult_arbiter;
   localparam int N    = 192;
   localparam int NREQ = 2;
   localparam int TMO  = 16;
   localparam logic [N-1:0] P = {N{1'b1}} - (N'(1) << 64);

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_b [NREQ];
   logic [N-1:0]      a_b [NREQ];
   logic [N-1:0]      b_b [NREQ];
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] op_a;
   logic [NREQ*N-1:0] op_b;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [N-1:0]      result;
   logic              busy;
   logic              err;
   logic [N-1:0]      mul_a;
   logic [N-1:0]      mul_b;
   logic              mul_rst;
   logic [N-1:0]      mul_m = '0;
   logic              mul_flag = 1'b0;
   int                lat = 0;
   bit                hang = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      req  = '0;
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         req[i]          = req_b[i];
         op_a[i*N +: N]  = a_b[i];
         op_b[i*N +: N]  = b_b[i];
      end
   end

   mod_mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk_i      (clk),
      .reset_i    (reset_n),
      .req_i      (req),
      .op_a_i     (op_a),
      .op_b_i     (op_b),
      .gnt_o      (gnt),
      .done_o     (done),
      .result_o   (result),
      .busy_o     (busy),
      .err_o      (err),
      .mul_a_o    (mul_a),
      .mul_b_o    (mul_b),
      .mul_rst_o  (mul_rst),
      .mul_m_i    (mul_m),
      .mul_flag_i (mul_flag)
   );

   function automatic logic [N-1:0] modmul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] pr;
      pr = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      pr = pr % {{N{1'b0}}, P};
      return pr[N-1:0];
   endfunction

   function automatic logic [N-1:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Round-robin reference: first requester at or after p, modulo NREQ.
   function automatic int rr(input int p, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         if (((r >> ((p + k) % NREQ)) & NREQ'(1)) != '0) return (p + k) % NREQ;
      end
      return 0;
   endfunction

   // Multiplier model: random latency after reset release, then flag + product.
   always @(posedge clk) begin
      if (mul_rst) begin
         mul_flag <= 1'b0;
         lat      <= int'($urandom_range(4, 0));
      end else if (!mul_flag && !hang) begin
         if (lat == 0) begin
            mul_flag <= 1'b1;
            mul_m    <= modmul(mul_a, mul_b);
         end else begin
            lat <= lat - 1;
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [N-1:0] exp_q [NREQ][$];
   int  gseq[$];
   int  gcyc[$];
   int  dcyc[$];
   int  cyc = 0;
   int  mptr = 0;
   int  exp_g = 0;
   int  didx = 0;
   bit  gchk = 1'b0;
   bit  lchk = 1'b0;
   bit  pdone = 1'b0;
   bit  tmo_mode = 1'b0;
   bit  no_gnt0 = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         mptr  = 0;
         gchk  = 1'b0;
         lchk  = 1'b0;
         pdone = 1'b0;
      end else begin
         if (lchk) begin
            chk("wait mul_rst", N'(mul_rst), N'(1'b0));
            lchk = 1'b0;
         end
         if (gchk) begin
            chk("grant", N'(gnt), N'(NREQ'(1) << exp_g));
            chk("load mul_rst", N'(mul_rst), N'(1'b1));
            chk("load busy", N'(busy), N'(1'b1));
            chk("mul_a", mul_a, a_b[exp_g]);
            chk("mul_b", mul_b, b_b[exp_g]);
            gseq.push_back(exp_g);
            gcyc.push_back(cyc);
            gchk = 1'b0;
            lchk = 1'b1;
         end
         if (no_gnt0) chk("gnt0 quiet", N'(gnt[0]), N'(1'b0));
         if (pdone) begin
            chk("post-done busy", N'(busy), N'(1'b0));
            chk("post-done gnt", N'(gnt), N'(0));
            pdone = 1'b0;
         end
         if (done != '0) begin
            didx = 0;
            for (int k = 0; k < NREQ; k++) if (done[k]) didx = k;
            chk("done vs gnt", N'(done), N'(gnt));
            chk("err at done", N'(err), N'(tmo_mode));
            if (exp_q[didx].size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected done: got done=%0b expected none", done);
            end else begin
               chk($sformatf("result%0d", didx), result, exp_q[didx].pop_front());
            end
            mptr = (didx + 1) % NREQ;
            dcyc.push_back(cyc);
            pdone = 1'b1;
         end else if (!busy && req != '0) begin
            exp_g = rr(mptr, req);
            gchk  = 1'b1;
         end
      end
   end

   task automatic issue(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
      a_b[i]   = a;
      b_b[i]   = b;
      req_b[i] = 1'b1;
      if (push) exp_q[i].push_back(modmul(a, b));
   endtask

   task automatic wait_done(input int i, input int bound);
      int c;
      c = 0;
      while (c < bound && done[i] !== 1'b1) begin
         @(negedge clk);
         c++;
      end
      n_chk++;
      if (c >= bound) begin
         n_fail++;
         $display("FAIL done%0d wait: got no done in %0d cycles expected done", i, bound);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rq(input int i, input int nops, input int maxgap);
      for (int k = 0; k < nops; k++) begin
         int gap;
         gap = int'($urandom_range(maxgap, 0));
         if (gap > 0) begin
            req_b[i] = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         issue(i, rnd(), rnd(), 1'b1);
         wait_done(i, 300);
      end
      req_b[i] = 1'b0;
   endtask

   task automatic wait_wait_entry(input int bound, output int at);
      int c;
      c  = 0;
      at = 0;
      do begin
         @(negedge clk);
         c++;
      end while (c < bound && !(busy && !mul_rst && gnt != '0));
      at = cyc;
      n_chk++;
      if (c >= bound) begin
         n_fail++;
         $display("FAIL wait entry: got none in %0d cycles expected WAIT", bound);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      reset_n = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_b[i] = 1'b0;
         a_b[i]   = '0;
         b_b[i]   = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst gnt", N'(gnt), N'(0));
      chk("rst done", N'(done), N'(0));
      chk("rst err", N'(err), N'(0));
      chk("rst busy", N'(busy), N'(0));
      chk("rst result", result, N'(0));
      chk("rst mul_a", mul_a, N'(0));
      chk("rst mul_b", mul_b, N'(0));
      chk("rst mul_rst", N'(mul_rst), N'(1));

      @(posedge clk);
      #1;
      issue(0, N'(5), N'(7), 1'b1);
      wait_done(0, 100);
      req_b[0] = 1'b0;
      chk("single result", result, N'(35));

      no_gnt0 = 1'b1;
      issue(1, P - N'(1), P - N'(1), 1'b1);
      wait_done(1, 100);
      req_b[1] = 1'b0;
      no_gnt0 = 1'b0;
      chk("p192 result", result, N'(1));

      gseq.delete();
      gcyc.delete();
      dcyc.delete();
      fork
         rq(0, 1, 0);
         rq(1, 1, 0);
      join
      chk("simul count", N'(gseq.size()), N'(2));
      if (gseq.size() == 2 && dcyc.size() == 2) begin
         chk("simul first", N'(gseq[0]), N'(0));
         chk("simul second", N'(gseq[1]), N'(1));
         chk("simul idle gap", N'(gcyc[1] - dcyc[0]), N'(2));
      end

      gseq.delete();
      fork
         rq(0, 3, 0);
         rq(1, 3, 0);
      join
      chk("fair count", N'(gseq.size()), N'(6));
      for (int k = 0; k < gseq.size(); k++) chk($sformatf("fair %0d", k), N'(gseq[k]), N'(k % 2));

      rq(0, 1, 0);
      hang = 1'b1;
      issue(1, rnd(), rnd(), 1'b0);
      wait_wait_entry(50, w);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      for (int i = 0; i < NREQ; i++) req_b[i] = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      hang    = 1'b0;
      @(negedge clk);
      chk("abort done", N'(done), N'(0));
      chk("abort mul_rst", N'(mul_rst), N'(1));
      chk("abort gnt", N'(gnt), N'(0));
      chk("abort busy", N'(busy), N'(0));
      chk("abort result", result, N'(0));
      gseq.delete();
      @(posedge clk);
      #1;
      fork
         rq(0, 1, 0);
         rq(1, 1, 0);
      join
      if (gseq.size() > 0) chk("ptr after abort", N'(gseq[0]), N'(0));
      else chk("ptr after abort count", N'(gseq.size()), N'(1));

`ifdef MM_ARB_TIMEOUT_EN
      hang     = 1'b1;
      tmo_mode = 1'b1;
      dcyc.delete();
      issue(0, rnd(), rnd(), 1'b0);
      exp_q[0].push_back('0);
      wait_wait_entry(50, w);
      wait_done(0, 100);
      req_b[0] = 1'b0;
      if (dcyc.size() > 0) chk("timeout latency", N'(dcyc[dcyc.size()-1] - w), N'(TMO));
      else chk("timeout done count", N'(dcyc.size()), N'(1));
      tmo_mode = 1'b0;
      hang     = 1'b0;
`else
      hang = 1'b1;
      issue(0, rnd(), rnd(), 1'b0);
      wait_wait_entry(50, w);
      repeat (40) begin
         @(negedge clk);
         chk("stall busy", N'(busy), N'(1));
         chk("stall err", N'(err), N'(0));
      end
      @(posedge clk);
      #1;
      reset_n  = 1'b0;
      req_b[0] = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      hang    = 1'b0;
`endif

      @(posedge clk);
      #1;
      fork
         rq(0, 20, 3);
         rq(1, 20, 3);
      join
      repeat (5) @(posedge clk);
      for (int i = 0; i < NREQ; i++) chk($sformatf("queue%0d empty", i), N'(exp_q[i].size()), N'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
